// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard, forwarding and stall control for the five-stage
// LEGv8 pipeline (IF/ID/EX/MEM/WB). It tracks which registers the instructions
// in EX, MEM and WB will write, and from that it produces:
//   - the PC and IF/ID load enables,
//   - the IF/ID flush and the EX bubble,
//   - the EX-operand and ID-read forwarding selects,
//   - saturating stall and flush event counters.
//
// Control-output handshake: there is no valid/ready pair here. Every enable,
// flush, fwd and byp output is a pure combinational function of the current
// scoreboard and the ID/EX inputs. The datapath samples them on the same
// rising clk edge that updates this unit's state. ext_stall freezes
// everything: no state moves and all enables and flushes read 0.
module pipe_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stall,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_r2,
    input  logic              id_uses_rn,
    input  logic              id_uses_r2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_byp_a,
    output logic              id_byp_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Source fields are only looked at while an instruction sits in EX, so
    // MEM and WB keep just the destination-side fields that forwarding needs.
    logic              id_valid_q, id_valid_d;

    logic              ex_valid_q, ex_valid_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic [REG_AW-1:0] ex_rn_q, ex_rn_d;
    logic [REG_AW-1:0] ex_r2_q, ex_r2_d;
    logic              ex_uses_rn_q, ex_uses_rn_d;
    logic              ex_uses_r2_q, ex_uses_r2_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;

    logic              mem_valid_q, mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_reg_write_q, mem_reg_write_d;
    logic              mem_mem_read_q, mem_mem_read_d;

    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic              wb_reg_write_q, wb_reg_write_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic branch_hit;
    logic load_use_hit;

    // EX-operand source select. A load still in MEM has no data yet, so it is
    // not a MEM forwarding source. MEM is checked first because it is younger.
    function automatic logic [1:0] ex_fwd_sel(
        input logic              active,
        input logic [REG_AW-1:0] src,
        input logic              m_valid,
        input logic              m_reg_write,
        input logic              m_mem_read,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_valid,
        input logic              w_reg_write,
        input logic [REG_AW-1:0] w_rd
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (active && src != ZERO_ADDR) begin
            if (m_valid && m_reg_write && !m_mem_read && m_rd == src) begin
                sel = SEL_MEM;
            end else if (w_valid && w_reg_write && w_rd == src) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // Hazard detection: taken branch in EX and load-use between EX and ID.
    always_comb begin
        branch_hit   = ex_valid_q & ex_branch_taken;
        load_use_hit = ex_valid_q & ex_mem_read_q & ex_reg_write_q &
                       (ex_rd_q != ZERO_ADDR) & id_valid_q &
                       ((id_uses_rn & (id_rn == ex_rd_q)) |
                        (id_uses_r2 & (id_r2 == ex_rd_q)));
    end

    // Pipeline enables and flushes: freeze, then branch, then load-use, then flow.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (ext_stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (branch_hit) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Forwarding selects for EX operands and for the ID register-file reads.
    always_comb begin
        fwd_a = ex_fwd_sel(ex_valid_q & ex_uses_rn_q, ex_rn_q,
                           mem_valid_q, mem_reg_write_q, mem_mem_read_q, mem_rd_q,
                           wb_valid_q, wb_reg_write_q, wb_rd_q);
        fwd_b = ex_fwd_sel(ex_valid_q & ex_uses_r2_q, ex_r2_q,
                           mem_valid_q, mem_reg_write_q, mem_mem_read_q, mem_rd_q,
                           wb_valid_q, wb_reg_write_q, wb_rd_q);
        id_byp_a = wb_valid_q & wb_reg_write_q & (wb_rd_q == id_rn) &
                   (id_rn != ZERO_ADDR) & id_uses_rn;
        id_byp_b = wb_valid_q & wb_reg_write_q & (wb_rd_q == id_r2) &
                   (id_r2 != ZERO_ADDR) & id_uses_r2;
    end

    // Next scoreboard and counter values; everything holds under ext_stall.
    always_comb begin
        id_valid_d      = id_valid_q;
        ex_valid_d      = ex_valid_q;
        ex_rd_d         = ex_rd_q;
        ex_rn_d         = ex_rn_q;
        ex_r2_d         = ex_r2_q;
        ex_uses_rn_d    = ex_uses_rn_q;
        ex_uses_r2_d    = ex_uses_r2_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        mem_valid_d     = mem_valid_q;
        mem_rd_d        = mem_rd_q;
        mem_reg_write_d = mem_reg_write_q;
        mem_mem_read_d  = mem_mem_read_q;
        wb_valid_d      = wb_valid_q;
        wb_rd_d         = wb_rd_q;
        wb_reg_write_d  = wb_reg_write_q;
        stall_cnt_d     = stall_cnt_q;
        flush_cnt_d     = flush_cnt_q;
        if (!ext_stall) begin
            wb_valid_d      = mem_valid_q;
            wb_rd_d         = mem_rd_q;
            wb_reg_write_d  = mem_reg_write_q;
            mem_valid_d     = ex_valid_q;
            mem_rd_d        = ex_rd_q;
            mem_reg_write_d = ex_reg_write_q;
            mem_mem_read_d  = ex_mem_read_q;
            ex_valid_d      = id_valid_q & ~idex_flush;
            ex_rd_d         = id_rd;
            ex_rn_d         = id_rn;
            ex_r2_d         = id_r2;
            ex_uses_rn_d    = id_uses_rn;
            ex_uses_r2_d    = id_uses_r2;
            ex_reg_write_d  = id_reg_write;
            ex_mem_read_d   = id_mem_read;
            if (ifid_en) begin
                id_valid_d = ~ifid_flush;
            end
            // A branch in the same cycle as a load-use is a flush, not a stall.
            if (branch_hit && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
            if (!branch_hit && load_use_hit && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset wipes every stage so no partial flush survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid_q      <= 1'b0;
            ex_valid_q      <= 1'b0;
            ex_rd_q         <= '0;
            ex_rn_q         <= '0;
            ex_r2_q         <= '0;
            ex_uses_rn_q    <= 1'b0;
            ex_uses_r2_q    <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_valid_q     <= 1'b0;
            mem_rd_q        <= '0;
            mem_reg_write_q <= 1'b0;
            mem_mem_read_q  <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            id_valid_q      <= id_valid_d;
            ex_valid_q      <= ex_valid_d;
            ex_rd_q         <= ex_rd_d;
            ex_rn_q         <= ex_rn_d;
            ex_r2_q         <= ex_r2_d;
            ex_uses_rn_q    <= ex_uses_rn_d;
            ex_uses_r2_q    <= ex_uses_r2_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_valid_q     <= mem_valid_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            mem_mem_read_q  <= mem_mem_read_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            stall_cnt_q     <= stall_cnt_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit. Directed per-cycle vectors: the driver
// applies the ID/EX inputs for one cycle and queues the hand-computed
// outputs; the monitor compares the DUT on every falling edge.
// A second instance with 2-bit counters shares the stimulus so that
// counter saturation is visible.
module tb_pipe_hazard_unit;

    localparam int W = 76;

    logic       clk;
    logic       rst;
    logic       ext_stall;
    logic [4:0] id_rn, id_r2, id_rd;
    logic       id_uses_rn, id_uses_r2, id_reg_write, id_mem_read;
    logic       ex_branch_taken;

    logic        pc_en, ifid_en, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        id_byp_a, id_byp_b;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_id_byp_a, s_id_byp_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_tests;
    int           n_fail;
    int           cyc_no;

    pipe_hazard_unit #(.REG_AW(5), .ZERO_REG(31), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ext_stall(ext_stall),
        .id_rn(id_rn), .id_r2(id_r2),
        .id_uses_rn(id_uses_rn), .id_uses_r2(id_uses_r2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_unit #(.REG_AW(5), .ZERO_REG(31), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .ext_stall(ext_stall),
        .id_rn(id_rn), .id_r2(id_r2),
        .id_uses_rn(id_uses_rn), .id_uses_r2(id_uses_r2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .id_byp_a(s_id_byp_a), .id_byp_b(s_id_byp_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction encoding: {rn, r2, uses_rn, uses_r2, rd, reg_write, mem_read}.
    function automatic logic [18:0] mk(input int rd, input int rn, input int r2,
                                       input logic urn, input logic ur2,
                                       input logic rw, input logic mr);
        return {5'(rn), 5'(r2), urn, ur2, 5'(rd), rw, mr};
    endfunction

    // Driver: one cycle of inputs plus the outputs expected during that cycle.
    task automatic step(input logic rs, input logic xs, input logic bt,
                        input logic [18:0] ins, input logic [3:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic ba, input logic bb,
                        input int sc, input int fc, input int ssc);
        @(posedge clk);
        #1;
        rst             = rs;
        ext_stall       = xs;
        ex_branch_taken = bt;
        {id_rn, id_r2, id_uses_rn, id_uses_r2, id_rd, id_reg_write, id_mem_read} = ins;
        exp_q.push_back({ctl, fa, fb, ba, bb, 32'(sc), 32'(fc), 2'(ssc)});
        tag_q.push_back(cyc_no);
        cyc_no++;
    endtask

    // Scoreboard monitor: compares on the falling edge, away from the update edge.
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        int           tag;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            got  = {pc_en, ifid_en, ifid_flush, idex_flush, fwd_a, fwd_b,
                    id_byp_a, id_byp_b, stall_cnt, flush_cnt, s_stall_cnt};
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL cycle_%0d: got ctl=%b fa=%b fb=%b byp=%b%b stall=%0d flush=%0d sstall=%0d, expected ctl=%b fa=%b fb=%b byp=%b%b stall=%0d flush=%0d sstall=%0d",
                         tag, got[75:72], got[71:70], got[69:68], got[67], got[66],
                         got[65:34], got[33:2], got[1:0],
                         want[75:72], want[71:70], want[69:68], want[67], want[66],
                         want[65:34], want[33:2], want[1:0]);
            end
        end
    end

    initial begin
        logic [3:0]  NRM, STL, BRF, FRZ;
        logic [18:0] NOP, ADD1, SUB2, ADD7, SUB10, ADD12, ORR15, LD4, ADD5, CBZ;
        logic [18:0] ADD21, ADD24, LD31, ADD2Z, ADD31, ADD3Z, LD8, ADD10;
        logic [18:0] LD12, ADD14, LD16, ADD18, LD19, ADD22, LD2, USE2;

        // {pc_en, ifid_en, ifid_flush, idex_flush}
        NRM = 4'b1100;
        STL = 4'b0001;
        BRF = 4'b1111;
        FRZ = 4'b0000;

        NOP   = mk(31, 31, 31, 0, 0, 0, 0);
        ADD1  = mk(1, 2, 3, 1, 1, 1, 0);
        SUB2  = mk(2, 1, 3, 1, 1, 1, 0);
        ADD7  = mk(7, 8, 9, 1, 1, 1, 0);
        SUB10 = mk(10, 7, 11, 1, 1, 1, 0);
        ADD12 = mk(12, 13, 14, 1, 1, 1, 0);
        ORR15 = mk(15, 12, 12, 1, 1, 1, 0);
        LD4   = mk(4, 5, 31, 1, 0, 1, 1);
        ADD5  = mk(5, 4, 6, 1, 1, 1, 0);
        CBZ   = mk(31, 31, 20, 0, 1, 0, 0);
        ADD21 = mk(21, 5, 23, 1, 1, 1, 0);
        ADD24 = mk(24, 25, 26, 1, 1, 1, 0);
        LD31  = mk(31, 1, 31, 1, 0, 1, 1);
        ADD2Z = mk(2, 31, 31, 1, 1, 1, 0);
        ADD31 = mk(31, 7, 7, 1, 1, 1, 0);
        ADD3Z = mk(3, 31, 31, 1, 1, 1, 0);
        LD8   = mk(8, 9, 31, 1, 0, 1, 1);
        ADD10 = mk(10, 11, 8, 1, 1, 1, 0);
        LD12  = mk(12, 13, 31, 1, 0, 1, 1);
        ADD14 = mk(14, 12, 15, 1, 1, 1, 0);
        LD16  = mk(16, 17, 31, 1, 0, 1, 1);
        ADD18 = mk(18, 16, 16, 1, 1, 1, 0);
        LD19  = mk(19, 20, 31, 1, 0, 1, 1);
        ADD22 = mk(22, 19, 22, 1, 1, 1, 0);
        LD2   = mk(2, 3, 31, 1, 0, 1, 1);
        USE2  = mk(6, 2, 7, 1, 1, 1, 0);

        n_tests = 0;
        n_fail  = 0;
        cyc_no  = 0;
        rst = 1'b0;
        ext_stall = 1'b0;
        ex_branch_taken = 1'b0;
        {id_rn, id_r2, id_uses_rn, id_uses_r2, id_rd, id_reg_write, id_mem_read} = NOP;

        // Reset held for three cycles, then released.
        repeat (3) step(0, 0, 0, NOP, NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        // Back-to-back dependency: MEM forward.
        step(1, 0, 0, ADD1,  NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, SUB2,  NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, ADD7,  NRM, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        // One NOP in between: WB forward.
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, SUB10, NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, ADD12, NRM, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        // Two NOPs in between: ID bypass on both operands.
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, ORR15, NRM, 2'b00, 2'b00, 1, 1, 0, 0, 0);
        // Load-use: one stall cycle, then WB forward.
        step(1, 0, 0, LD4,   NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, ADD5,  STL, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, ADD5,  NRM, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(1, 0, 0, CBZ,   NRM, 2'b10, 2'b00, 0, 0, 1, 0, 1);
        // Taken branch: flush, then two dead EX slots.
        step(1, 0, 1, ADD21, BRF, 2'b00, 2'b00, 0, 0, 1, 0, 1);
        step(1, 0, 0, ADD24, NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        // X31 as destination never causes stall, forward or bypass.
        step(1, 0, 0, LD31,  NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, ADD2Z, NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, ADD31, NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, ADD3Z, NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        // Pending load-use frozen by ext_stall for four cycles.
        step(1, 0, 0, LD8,   NRM, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        repeat (4) step(1, 1, 0, ADD10, FRZ, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, ADD10, STL, 2'b00, 2'b00, 0, 0, 1, 1, 1);
        step(1, 0, 0, ADD10, NRM, 2'b00, 2'b00, 0, 0, 2, 1, 2);
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b10, 0, 0, 2, 1, 2);
        // Two more load-use stalls drive the 2-bit counter into saturation.
        step(1, 0, 0, LD12,  NRM, 2'b00, 2'b00, 0, 0, 2, 1, 2);
        step(1, 0, 0, ADD14, STL, 2'b00, 2'b00, 0, 0, 2, 1, 2);
        step(1, 0, 0, ADD14, NRM, 2'b00, 2'b00, 0, 0, 3, 1, 3);
        step(1, 0, 0, LD16,  NRM, 2'b10, 2'b00, 0, 0, 3, 1, 3);
        step(1, 0, 0, ADD18, STL, 2'b00, 2'b00, 0, 0, 3, 1, 3);
        step(1, 0, 0, ADD18, NRM, 2'b00, 2'b00, 0, 0, 4, 1, 3);
        step(1, 0, 0, LD19,  NRM, 2'b10, 2'b10, 0, 0, 4, 1, 3);
        // Branch and load-use together, first deferred by ext_stall; branch wins.
        step(1, 1, 1, ADD22, FRZ, 2'b00, 2'b00, 0, 0, 4, 1, 3);
        step(1, 0, 1, ADD22, BRF, 2'b00, 2'b00, 0, 0, 4, 1, 3);
        step(1, 0, 0, NOP,   NRM, 2'b00, 2'b00, 0, 0, 4, 2, 3);
        // Reset in the middle of a stall clears everything immediately.
        step(1, 0, 0, LD2,   NRM, 2'b00, 2'b00, 0, 0, 4, 2, 3);
        step(1, 0, 0, USE2,  STL, 2'b00, 2'b00, 0, 0, 4, 2, 3);
        step(0, 0, 0, USE2,  NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, USE2,  NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        step(1, 0, 0, USE2,  NRM, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        // Let the monitor drain the queue within a fixed budget.
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
